// File: rtl/tictactoe_pkg.sv
// Shared types, board geometry and small helpers for the tic-tac-toe move sequencer.
// Cell i of the board lives at bits [2i+1:2i].
package tictactoe_pkg;

  typedef enum logic [1:0] {EMPTY = 2'b00, PX = 2'b01, PO = 2'b10} cell_t;
  typedef enum logic [1:0] {NONE = 2'b00, X_WIN = 2'b01, O_WIN = 2'b10, DRAW = 2'b11} result_t;
  typedef enum logic [1:0] {S_PLAY, S_CHECK, S_DONE} state_t;

  localparam int NUM_CELLS = 9;
  localparam int BOARD_W   = 18;

  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == PX) ? PO : PX;
  endfunction

  function automatic logic [3:0] count_filled(input logic [BOARD_W-1:0] b);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < NUM_CELLS; i++)
      if (b[2*i +: 2] != EMPTY) n = n + 4'd1;
    return n;
  endfunction

  function automatic logic has_bad_cell(input logic [BOARD_W-1:0] b);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++)
      if (b[2*i +: 2] == 2'b11) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/board_ctrl_move_legal.sv
// Combinational move legality: target must be 0..8 and currently empty.
// wr_mask is one-hot on the target cell whenever the index is in range.
module move_legal
  import tictactoe_pkg::*;
(
  input  logic [BOARD_W-1:0]   g_board,
  input  logic [3:0]           move_cell,
  output logic                 legal,
  output logic [NUM_CELLS-1:0] wr_mask
);

  always_comb begin
    legal   = 1'b0;
    wr_mask = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (move_cell == 4'(i)) begin
        wr_mask[i] = 1'b1;
        legal      = (g_board[2*i +: 2] == EMPTY);
      end
    end
  end

endmodule

// File: rtl/board_ctrl.sv
// Move sequencer feeding the win detector: board visible 1 cycle after accept, result 2 cycles after.
// move_ready drops during the check cycle, once the game is over, and whenever new_game is high.
module board_ctrl
  import tictactoe_pkg::*;
#(
  parameter logic [1:0] FIRST_PLAYER = 2'b01,
  parameter bit         ALT_START    = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               new_game,
  input  logic               move_valid,
  input  logic [3:0]         move_cell,
  output logic               move_ready,
  output logic               move_err,
  output logic [BOARD_W-1:0] g_board,
  output logic [1:0]         turn,
  output logic [3:0]         move_count,
  input  logic               game_is_done,
  input  logic [1:0]         winner_in,
  output logic               game_over,
  output logic [1:0]         result
);

  state_t                 state;
  logic [1:0]             start_pl;
  logic                   legal;
  logic [NUM_CELLS-1:0]   wr_mask;
  logic [BOARD_W-1:0]     board_nx;
  logic                   accept;

  move_legal u_legal (
    .g_board   (g_board),
    .move_cell (move_cell),
    .legal     (legal),
    .wr_mask   (wr_mask)
  );

  assign move_ready = (state == S_PLAY) && !new_game;
  assign accept     = move_valid && move_ready;

  always_comb begin
    board_nx = g_board;
    for (int i = 0; i < NUM_CELLS; i++)
      if (wr_mask[i]) board_nx[2*i +: 2] = turn;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      g_board    <= '0;
      move_count <= 4'd0;
      turn       <= FIRST_PLAYER;
      start_pl   <= FIRST_PLAYER;
      result     <= NONE;
      game_over  <= 1'b0;
      move_err   <= 1'b0;
      state      <= S_PLAY;
    end else if (new_game) begin
      g_board    <= '0;
      move_count <= 4'd0;
      result     <= NONE;
      game_over  <= 1'b0;
      move_err   <= 1'b0;
      state      <= S_PLAY;
      if (ALT_START) begin
        start_pl <= other_player(start_pl);
        turn     <= other_player(start_pl);
      end else begin
        start_pl <= FIRST_PLAYER;
        turn     <= FIRST_PLAYER;
      end
    end else begin
      move_err <= 1'b0;
      case (state)
        S_PLAY: begin
          if (accept) begin
            if (legal) begin
              g_board <= board_nx;
              if (move_count < 4'd9) move_count <= move_count + 4'd1;
              state <= S_CHECK;
            end else begin
              move_err <= 1'b1;
            end
          end
        end
        S_CHECK: begin
          // A reserved winner code 11 is treated as no winner.
          if (game_is_done) begin
            result    <= (winner_in == DRAW) ? NONE : winner_in;
            turn      <= EMPTY;
            game_over <= 1'b1;
            state     <= S_DONE;
          end else if (move_count == 4'd9) begin
            result    <= DRAW;
            turn      <= EMPTY;
            game_over <= 1'b1;
            state     <= S_DONE;
          end else begin
            turn  <= other_player(turn);
            state <= S_PLAY;
          end
        end
        S_DONE:  ;
        default: state <= S_PLAY;
      endcase
    end
  end

  a_no_bad_cell: assert property (@(posedge clk) disable iff (!reset)
    !has_bad_cell(g_board));
  a_count_match: assert property (@(posedge clk) disable iff (!reset)
    count_filled(g_board) == move_count);
  a_winner_code: assert property (@(posedge clk) disable iff (!reset)
    (state == S_CHECK && game_is_done) |-> (winner_in != 2'b11));

endmodule

// File: tb/tb_board_ctrl.sv
// Scoreboard bench for board_ctrl: the driver queues hand-computed responses per move,
// a negedge monitor pops them at each handshake and checks the 1- and 2-cycle responses.
module tb_board_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        new_game = 1'b0;
  logic        move_valid = 1'b0;
  logic [3:0]  move_cell = 4'd0;
  logic        move_ready, move_err, game_is_done, game_over;
  logic [17:0] g_board;
  logic [1:0]  turn, winner_in, result;
  logic [3:0]  move_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        err;
    logic [17:0] board;
    logic [3:0]  count;
    bit          chk2;
    logic [1:0]  res;
    logic        over;
    logic [1:0]  trn;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  board_ctrl #(.FIRST_PLAYER(2'b01), .ALT_START(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .new_game     (new_game),
    .move_valid   (move_valid),
    .move_cell    (move_cell),
    .move_ready   (move_ready),
    .move_err     (move_err),
    .g_board      (g_board),
    .turn         (turn),
    .move_count   (move_count),
    .game_is_done (game_is_done),
    .winner_in    (winner_in),
    .game_over    (game_over),
    .result       (result)
  );

  // Reference win detector: reports only completed lines, never a full board.
  function automatic logic [2:0] detect(input logic [17:0] b);
    int ln[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                     '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    logic [1:0] a, m, c;
    for (int l = 0; l < 8; l++) begin
      a = b[2*ln[l][0] +: 2];
      m = b[2*ln[l][1] +: 2];
      c = b[2*ln[l][2] +: 2];
      if (a != 2'b00 && a == m && a == c) return {1'b1, a};
    end
    return 3'b000;
  endfunction

  assign {game_is_done, winner_in} = detect(g_board);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic err, input logic [17:0] board, input logic [3:0] count,
                              input bit chk2, input logic [1:0] res, input logic over,
                              input logic [1:0] trn);
    exp_t e;
    e.err = err; e.board = board; e.count = count; e.chk2 = chk2;
    e.res = res; e.over = over; e.trn = trn;
    return e;
  endfunction

  // Monitor: handshake seen at a negedge -> compare one and two cycles later.
  exp_t r1, r2;
  bit   p1 = 1'b0, p2 = 1'b0;
  initial forever begin
    @(negedge clk);
    if (p2) begin
      chk("sb_err_cleared", 32'(move_err), 32'(1'b0));
      chk("sb_result",      32'(result),   32'(r2.res));
      chk("sb_game_over",   32'(game_over), 32'(r2.over));
      chk("sb_turn",        32'(turn),     32'(r2.trn));
    end
    p2 = 1'b0;
    if (p1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_accept actual=accept required=none");
      end else begin
        r1 = q.pop_front();
        chk("sb_err",   32'(move_err),   32'(r1.err));
        chk("sb_board", 32'(g_board),    32'(r1.board));
        chk("sb_count", 32'(move_count), 32'(r1.count));
        if (r1.chk2) begin
          r2 = r1;
          p2 = 1'b1;
        end
      end
    end
    p1 = reset && move_valid && move_ready;
  end

  task automatic do_move(input logic [3:0] c, input exp_t e, input bit ng_in_check);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    move_valid = 1'b1;
    move_cell  = c;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (move_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL move_ready_timeout actual=0 required=1 cell=%0d", c);
      move_valid = 1'b0;
      return;
    end
    q.push_back(e);
    @(posedge clk); #1;
    move_valid = 1'b0;
    if (ng_in_check) begin
      new_game = 1'b1;
      @(posedge clk); #1;
      new_game = 1'b0;
    end
  endtask

  task automatic pulse_new_game();
    @(posedge clk); #1;
    new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
  endtask

  task automatic frozen_probe(input string nm);
    @(posedge clk); #1;
    move_valid = 1'b1;
    move_cell  = 4'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk({nm, "_no_ack"}, 32'(move_ready), 32'(1'b0));
      chk({nm, "_no_err"}, 32'(move_err),   32'(1'b0));
    end
    @(posedge clk); #1;
    move_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_board",  32'(g_board),    32'(0));
    chk("rst_turn",   32'(turn),       32'(2'b01));
    chk("rst_count",  32'(move_count), 32'(0));
    chk("rst_result", 32'(result),     32'(0));
    chk("rst_ready",  32'(move_ready), 32'(1));
    chk("rst_over",   32'(game_over),  32'(0));

    // Illegal moves: occupied cell, then out-of-range cell
    do_move(4'd4,  mk(1'b0, 18'h00100, 4'd1, 1'b1, 2'b00, 1'b0, 2'b10), 1'b0);
    do_move(4'd4,  mk(1'b1, 18'h00100, 4'd1, 1'b1, 2'b00, 1'b0, 2'b10), 1'b0);
    do_move(4'd11, mk(1'b1, 18'h00100, 4'd1, 1'b1, 2'b00, 1'b0, 2'b10), 1'b0);
    repeat (3) @(negedge clk);
    chk("illegal_count", 32'(move_count), 32'(1));

    // new_game with simultaneous move_valid
    @(posedge clk); #1;
    new_game = 1'b1; move_valid = 1'b1; move_cell = 4'd0;
    @(negedge clk);
    chk("ng_ready_low", 32'(move_ready), 32'(0));
    @(posedge clk); #1;
    new_game = 1'b0; move_valid = 1'b0;
    @(negedge clk);
    chk("ng_board", 32'(g_board),    32'(0));
    chk("ng_count", 32'(move_count), 32'(0));
    chk("ng_turn",  32'(turn),       32'(2'b10));
    pulse_new_game();
    @(negedge clk);
    chk("ng2_turn", 32'(turn), 32'(2'b01));

    // X row win on the top row
    do_move(4'd0, mk(1'b0, 18'h00001, 4'd1, 1'b1, 2'b00, 1'b0, 2'b10), 1'b0);
    do_move(4'd3, mk(1'b0, 18'h00081, 4'd2, 1'b1, 2'b00, 1'b0, 2'b01), 1'b0);
    do_move(4'd1, mk(1'b0, 18'h00085, 4'd3, 1'b1, 2'b00, 1'b0, 2'b10), 1'b0);
    do_move(4'd4, mk(1'b0, 18'h00285, 4'd4, 1'b1, 2'b00, 1'b0, 2'b01), 1'b0);
    do_move(4'd2, mk(1'b0, 18'h00295, 4'd5, 1'b1, 2'b01, 1'b1, 2'b00), 1'b0);
    repeat (3) @(negedge clk);
    frozen_probe("win_frozen");
    chk("win_board_hold", 32'(g_board), 32'(18'h00295));

    // Draw: start player toggles to O then back to X
    pulse_new_game();
    pulse_new_game();
    do_move(4'd0, mk(1'b0, 18'h00001, 4'd1, 1'b1, 2'b00, 1'b0, 2'b10), 1'b0);
    do_move(4'd1, mk(1'b0, 18'h00009, 4'd2, 1'b1, 2'b00, 1'b0, 2'b01), 1'b0);
    do_move(4'd2, mk(1'b0, 18'h00019, 4'd3, 1'b1, 2'b00, 1'b0, 2'b10), 1'b0);
    do_move(4'd4, mk(1'b0, 18'h00219, 4'd4, 1'b1, 2'b00, 1'b0, 2'b01), 1'b0);
    do_move(4'd3, mk(1'b0, 18'h00259, 4'd5, 1'b1, 2'b00, 1'b0, 2'b10), 1'b0);
    do_move(4'd5, mk(1'b0, 18'h00A59, 4'd6, 1'b1, 2'b00, 1'b0, 2'b01), 1'b0);
    do_move(4'd7, mk(1'b0, 18'h04A59, 4'd7, 1'b1, 2'b00, 1'b0, 2'b10), 1'b0);
    do_move(4'd6, mk(1'b0, 18'h06A59, 4'd8, 1'b1, 2'b00, 1'b0, 2'b01), 1'b0);
    do_move(4'd8, mk(1'b0, 18'h16A59, 4'd9, 1'b1, 2'b11, 1'b1, 2'b00), 1'b0);
    repeat (3) @(negedge clk);
    frozen_probe("draw_frozen");
    chk("draw_count", 32'(move_count), 32'(9));

    // new_game during the check cycle of O's winning move
    pulse_new_game();
    do_move(4'd0, mk(1'b0, 18'h00002, 4'd1, 1'b1, 2'b00, 1'b0, 2'b01), 1'b0);
    do_move(4'd3, mk(1'b0, 18'h00042, 4'd2, 1'b1, 2'b00, 1'b0, 2'b10), 1'b0);
    do_move(4'd1, mk(1'b0, 18'h0004A, 4'd3, 1'b1, 2'b00, 1'b0, 2'b01), 1'b0);
    do_move(4'd4, mk(1'b0, 18'h0014A, 4'd4, 1'b1, 2'b00, 1'b0, 2'b10), 1'b0);
    do_move(4'd2, mk(1'b0, 18'h0016A, 4'd5, 1'b0, 2'b00, 1'b0, 2'b00), 1'b1);
    @(negedge clk);
    chk("ngchk_board",  32'(g_board),    32'(0));
    chk("ngchk_count",  32'(move_count), 32'(0));
    chk("ngchk_result", 32'(result),     32'(0));
    chk("ngchk_over",   32'(game_over),  32'(0));
    chk("ngchk_ready",  32'(move_ready), 32'(1));
    chk("ngchk_turn",   32'(turn),       32'(2'b01));
    repeat (2) @(negedge clk);
    chk("ngchk_result_hold", 32'(result), 32'(0));

    chk("sb_drained", 32'(q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
